vred_logic_accum: RTL

Multi-beat accumulator for vector AND/OR/XOR reductions. It sits directly downstream of the pairwise AND/OR/XOR reduction unit and consumes that unit's per-beat partial results, one DATA_WIDTH word per beat. It folds each beat into a running accumulator seeded with the scalar operand. On the final beat it presents the reduced scalar to the writeback stage through a valid/ready handshake.

---
 rtl/vred_logic_accum.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/vred_logic_accum.sv
// Multi-beat AND/OR/XOR reduction accumulator: folds per-beat partials into a seeded running value.
// Latency: result valid the cycle after the last beat is accepted (start-to-result minimum 2 cycles).
// Backpressure: in_ready only in ACCUM; result held in HOLD until out_ready. Optional VRED_ACCUM_CNT_EN adds out_count.
module vred_logic_accum #(
  parameter int DATA_WIDTH  = 32,
  parameter int OPSEL_WIDTH = 2
`ifdef VRED_ACCUM_CNT_EN
  ,
  parameter int CNT_WIDTH   = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_start,
  input  logic [DATA_WIDTH-1:0]  in_seed,
  input  logic [OPSEL_WIDTH-1:0] in_opSel,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_en,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  output logic                   out_busy
`ifdef VRED_ACCUM_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]   out_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [OPSEL_WIDTH-1:0] OP_NONE = '0;
  localparam logic [OPSEL_WIDTH-1:0] OP_AND  = OPSEL_WIDTH'(1);
  localparam logic [OPSEL_WIDTH-1:0] OP_OR   = OPSEL_WIDTH'(2);
  localparam logic [OPSEL_WIDTH-1:0] OP_XOR  = OPSEL_WIDTH'(3);

  state_t                 state;
  state_t                 state_nxt;
  logic [DATA_WIDTH-1:0]  acc;
  logic [DATA_WIDTH-1:0]  fold;
  logic [OPSEL_WIDTH-1:0] op;
  logic                   start_acc;
  logic                   beat_acc;

  // State register; reset aborts any reduction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode. A start in HOLD only counts when the
  // result is consumed in the same cycle, giving back-to-back reductions.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    beat_acc  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_busy  = 1'b1;
    case (state)
      IDLE: begin
        out_busy = 1'b0;
        if (in_start) begin
          start_acc = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          beat_acc = 1'b1;
          if (in_last) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (in_start) begin
            start_acc = 1'b1;
            state_nxt = ACCUM;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        out_busy  = 1'b0;
      end
    endcase
  end

  // Fold of the current beat into the accumulator; "none" collapses to zero.
  always_comb begin
    fold = '0;
    case (op)
      OP_AND:  fold = acc & in_data;
      OP_OR:   fold = acc | in_data;
      OP_XOR:  fold = acc ^ in_data;
      default: fold = '0;
    endcase
  end

  // Accumulator and latched operation. Op "none" seeds with zero so the
  // result is zero regardless of the beats; masked beats leave acc alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      op  <= '0;
    end else if (start_acc) begin
      acc <= (in_opSel == OP_NONE) ? '0 : in_seed;
      op  <= in_opSel;
    end else if (beat_acc && in_en) begin
      acc <= fold;
    end
  end

  assign out_data = acc;

`ifdef VRED_ACCUM_CNT_EN
  logic [CNT_WIDTH-1:0] cnt;

  // Saturating count of folded beats, cleared on every accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start_acc) begin
      cnt <= '0;
    end else if (beat_acc && in_en && (cnt != '1)) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  assign out_count = cnt;
`endif

endmodule
